alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port op_en  input  17  one-hot enables, bit0..16 = ADD,SUB,MUL,DIV,MOD,MAX,MIN,NOT,NAND,XNOR,SHL,SHRL,ROL,ROR,SLT,BEQ,BLT.
REQ-006 SHALL have ports a, b  input  DATA_W  operands, sampled on accept.
REQ-007 SHALL have port result  output  DATA_W  registered result, held until next done.
REQ-008 SHALL have port zero  output  1  result==0, registered with result.
REQ-009 SHALL have port branch_taken  output  1  BEQ/BLT outcome.
REQ-010 SHALL have port busy  output  1  high from accept cycle+1 until done cycle inclusive.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port err  output  1  illegal op_en or divide-by-zero, valid with done.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC (single-cycle ops) or ITER (MUL/DIV/MOD) -> DONE -> IDLE.
REQ-014 SHALL latch a, b, op_en on cycle where start=1 and state=IDLE; start at any other time SHALL be ignored.
REQ-015 Single-cycle ops SHALL assert done exactly 2 cycles after accept edge.
REQ-016 MUL/DIV/MOD SHALL use iterative shift-add / restoring divide, DATA_W iterations, done exactly DATA_W+2 cycles after accept.
REQ-017 ADD/SUB SHALL wrap modulo 2^DATA_W; MUL SHALL return low DATA_W bits of unsigned product.
REQ-018 DIV/MOD SHALL be unsigned; b==0 SHALL give quotient all-ones, remainder a, err=1.
REQ-019 MAX/MIN/SLT/BLT SHALL compare signed two's complement; SLT result = {0..,1} or 0.
REQ-020 NOT SHALL invert a; NAND/XNOR bitwise on a, b.
REQ-021 SHL/SHRL/ROL/ROR SHALL use amount b[$clog2(DATA_W)-1:0]; SHRL zero-fills.
REQ-022 BEQ SHALL set branch_taken=(a==b), BLT =(a<b signed); result SHALL be a-b; branch_taken SHALL be 0 for all other ops.
REQ-023 op_en with zero or >1 bits set SHALL complete as single-cycle op, result 0, err=1.
REQ-024 err, zero, branch_taken SHALL update only on done cycle and hold until next done.

Reset
REQ-025 rst SHALL force state IDLE, result=0, zero=0, branch_taken=0, busy=0, done=0, err=0, iteration counter 0.
REQ-026 rst asserted mid-ITER SHALL abort operation with no done pulse; rst SHALL take priority over start.

Configuration
REQ-027 Macro ALU_EXEC_FAST_MUL_EN defined SHALL route MUL through single-cycle path (REQ-015 latency); DIV/MOD remain iterative.
REQ-028 Without ALU_EXEC_FAST_MUL_EN MUL SHALL be iterative per REQ-016; results SHALL be identical in both builds.

Structure
REQ-029 Package alu_pkg SHALL hold op_en bit-index constants, op count (17), and FSM state enum.
REQ-030 Iterative MUL/DIV/MOD datapath SHALL be sub-module alu_iter_muldiv (start/done, counter, shift registers).

Verification
REQ-031 ADD a=0xFFFFFFFF b=1 -> done at accept+2, result 0, zero=1, err=0.
REQ-032 DIV a=100 b=7 -> done at accept+34, result 14; MOD same operands -> result 2; DIV b=0 -> result 0xFFFFFFFF, err=1.
REQ-033 BLT a=0xFFFFFFFE(-2) b=1 -> branch_taken=1; BEQ a=5 b=5 -> branch_taken=1, result 0.
REQ-034 op_en=0x00003 (ADD|SUB) -> result 0, err=1, done at accept+2.
REQ-035 MUL a=3 b=5 started, start re-pulsed during busy, rst at accept+10 -> no done, outputs 0; next MUL 6*7 -> 42.
REQ-036 ROR a=0x00000001 b=1 -> 0x80000000; SHRL a=0x80000000 b=31 -> 1; MIN a=-1 b=2 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_exec slice: op_en bit positions, op count,
// FSM states and the iterative mul/div mode.
package alu_pkg;

    localparam int OP_COUNT = 17;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_DIV  = 3;
    localparam int OP_MOD  = 4;
    localparam int OP_MAX  = 5;
    localparam int OP_MIN  = 6;
    localparam int OP_NOT  = 7;
    localparam int OP_NAND = 8;
    localparam int OP_XNOR = 9;
    localparam int OP_SHL  = 10;
    localparam int OP_SHRL = 11;
    localparam int OP_ROL  = 12;
    localparam int OP_ROR  = 13;
    localparam int OP_SLT  = 14;
    localparam int OP_BEQ  = 15;
    localparam int OP_BLT  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ITER,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIV,
        MD_MOD
    } md_mode_t;

    // Exactly one enable bit set; anything else is an illegal request.
    function automatic logic is_onehot(input logic [OP_COUNT-1:0] v);
        return (v != '0) && ((v & (v - OP_COUNT'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider; one bit per
// cycle for DATA_W cycles, then a one-cycle done pulse.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  md_mode_t          mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    md_mode_t          mode_q;
    logic [DATA_W-1:0] acc_q;   // product (MUL) or partial remainder (DIV/MOD)
    logic [DATA_W-1:0] x_q;     // multiplicand, or dividend shifting into quotient
    logic [DATA_W-1:0] y_q;     // multiplier or divisor
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_sub;
    logic              rem_ge;

    always_comb begin
        rem_sh  = {acc_q, x_q[DATA_W-1]};
        rem_sub = rem_sh - {1'b0, y_q};
        rem_ge  = (rem_sh >= {1'b0, y_q});
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                cnt_q <= CNT_W'(DATA_W);
            end else if (cnt_q != '0) begin
                cnt_q  <= cnt_q - CNT_W'(1);
                done_q <= (cnt_q == CNT_W'(1));
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on start
    // before being read, so a reset would only cost routing and gating.
    always_ff @(posedge clk) begin
        if (start) begin
            mode_q <= mode;
            acc_q  <= '0;
            x_q    <= a;
            y_q    <= b;
        end else if (cnt_q != '0) begin
            if (mode_q == MD_MUL) begin
                if (y_q[0]) acc_q <= acc_q + x_q;
                x_q <= x_q << 1;
                y_q <= y_q >> 1;
            end else begin
                // b==0 always subtracts: quotient all-ones, remainder = a.
                acc_q <= rem_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
                x_q   <= {x_q[DATA_W-2:0], rem_ge};
            end
        end
    end

    assign result = (mode_q == MD_DIV) ? x_q : acc_q;
    assign done   = done_q;

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU: one-hot op select, single-cycle and iterative paths, results
// registered and published with a one-cycle done pulse.
// Build option: define ALU_EXEC_FAST_MUL_EN to compute MUL on the single-cycle path.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_COUNT-1:0] op_en,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   result,
    output logic                zero,
    output logic                branch_taken,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SH_W = $clog2(DATA_W);

    state_t              state_q, state_d;
    logic [OP_COUNT-1:0] op_q;
    logic [DATA_W-1:0]   a_q, b_q;

    logic                accept;
    logic                is_iter;
    md_mode_t            md_mode;
    logic                iter_done;
    logic [DATA_W-1:0]   iter_result;

    logic [DATA_W-1:0]   res_d;
    logic                err_d;
    logic                bt_d;
    logic                lt_s;
    logic [SH_W-1:0]     sh;
    logic [2*DATA_W-1:0] rot_l, rot_r;

    assign busy   = (state_q != ST_IDLE) || done;
    assign accept = start && !busy;

    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        is_iter = is_onehot(op_en) && (op_en[OP_DIV] || op_en[OP_MOD]);
`ifndef ALU_EXEC_FAST_MUL_EN
        if (is_onehot(op_en) && op_en[OP_MUL]) is_iter = 1'b1;
`endif
        md_mode = op_en[OP_MUL] ? MD_MUL : (op_en[OP_DIV] ? MD_DIV : MD_MOD);

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = is_iter ? ST_ITER : ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_ITER: if (iter_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op_en;
            a_q  <= a;
            b_q  <= b;
        end
    end

    alu_iter_muldiv #(
        .DATA_W (DATA_W)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_iter),
        .mode   (md_mode),
        .a      (a),
        .b      (b),
        .result (iter_result),
        .done   (iter_done)
    );

    // Result selection from the latched operands; consumed only in ST_DONE.
    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        bt_d  = 1'b0;
        lt_s  = ($signed(a_q) < $signed(b_q));
        sh    = b_q[SH_W-1:0];
        rot_l = {a_q, a_q} << sh;
        rot_r = {a_q, a_q} >> sh;

        if (!is_onehot(op_q)) begin
            err_d = 1'b1;
        end else begin
            case (1'b1)
                op_q[OP_ADD]:  res_d = a_q + b_q;
                op_q[OP_SUB]:  res_d = a_q - b_q;
`ifdef ALU_EXEC_FAST_MUL_EN
                op_q[OP_MUL]:  res_d = a_q * b_q;
`else
                op_q[OP_MUL]:  res_d = iter_result;
`endif
                op_q[OP_DIV],
                op_q[OP_MOD]: begin
                    res_d = iter_result;
                    err_d = (b_q == '0);
                end
                op_q[OP_MAX]:  res_d = lt_s ? b_q : a_q;
                op_q[OP_MIN]:  res_d = lt_s ? a_q : b_q;
                op_q[OP_NOT]:  res_d = ~a_q;
                op_q[OP_NAND]: res_d = ~(a_q & b_q);
                op_q[OP_XNOR]: res_d = ~(a_q ^ b_q);
                op_q[OP_SHL]:  res_d = a_q << sh;
                op_q[OP_SHRL]: res_d = a_q >> sh;
                op_q[OP_ROL]:  res_d = rot_l[2*DATA_W-1:DATA_W];
                op_q[OP_ROR]:  res_d = rot_r[DATA_W-1:0];
                op_q[OP_SLT]:  res_d = {{(DATA_W-1){1'b0}}, lt_s};
                op_q[OP_BEQ]: begin
                    res_d = a_q - b_q;
                    bt_d  = (a_q == b_q);
                end
                op_q[OP_BLT]: begin
                    res_d = a_q - b_q;
                    bt_d  = lt_s;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            err          <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == ST_DONE) begin
                result       <= res_d;
                zero         <= (res_d == '0);
                branch_taken <= bt_d;
                err          <= err_d;
                done         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec: latency, arithmetic, logic,
// branch, illegal-op, busy handling and mid-operation reset.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_EXEC_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int ABORT_OP = OP_DIV;
`else
    localparam int MUL_LAT  = 34;
    localparam int ABORT_OP = OP_MUL;
`endif

    typedef struct {
        logic [16:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic         bt;
        logic         er;
        int           lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [16:0]   op_en = '0;
    logic [W-1:0]  a = '0, b = '0;
    logic [W-1:0]  result;
    logic          zero, branch_taken, busy, done, err;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_exec #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_en        (op_en),
        .a            (a),
        .b            (b),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    function automatic logic [16:0] opm(input int idx);
        return 17'(1) << idx;
    endfunction

    // Issue one request and wait for done; lat = edges from accept, -1 on timeout.
    task automatic run_op(input logic [16:0] m, input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int lat);
        @(negedge clk);
        op_en = m; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~va; b = ~vb; op_en = opm(OP_ADD);
        lat = -1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if (result !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        n_run++;
        if ({zero, branch_taken, busy, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {zero, branch_taken, busy, done, err});
        end
        rst = 1'b0;
    endtask

    task automatic test_handshake();
        @(negedge clk);
        op_en = opm(OP_ADD); a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_run++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL hs_accept busy/done: got %b expected 10", {busy, done});
        end
        @(posedge clk); #1;
        n_run++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_early_done: got %b expected 0", done);
        end
        @(posedge clk); #1;
        n_run++;
        if ({done, busy, result} !== {2'b11, 32'd5}) begin
            n_fail++;
            $display("FAIL hs_done: got done=%b busy=%b res=%h expected 1 1 5", done, busy, result);
        end
        @(posedge clk); #1;
        n_run++;
        if ({done, busy, result} !== {2'b00, 32'd5}) begin
            n_fail++;
            $display("FAIL hs_after: got done=%b busy=%b res=%h expected 0 0 5", done, busy, result);
        end
    endtask

    task automatic test_add_wrap();
        int lat;
        run_op(opm(OP_ADD), 32'hFFFF_FFFF, 32'd1, lat);
        n_run++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL add_wrap_latency: got %0d expected 2", lat);
        end
        n_run++;
        if ({result, zero, err} !== {32'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_wrap: got res=%h zero=%b err=%b expected 0 1 0", result, zero, err);
        end
    endtask

    task automatic test_single_cycle();
        vec_t v[20];
        int lat;
        v[0]  = '{opm(OP_SUB),  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0, 2};
        v[1]  = '{opm(OP_MUL),  32'd6,         32'd7,         32'd42,        1'b0, 1'b0, MUL_LAT};
        v[2]  = '{opm(OP_MUL),  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, MUL_LAT};
        v[3]  = '{opm(OP_MUL),  32'h0001_0000, 32'h0001_0000, 32'd0,         1'b0, 1'b0, MUL_LAT};
        v[4]  = '{opm(OP_MAX),  32'hFFFF_FFFF, 32'd2,         32'd2,         1'b0, 1'b0, 2};
        v[5]  = '{opm(OP_MIN),  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 2};
        v[6]  = '{opm(OP_NOT),  32'h0F0F_0F0F, 32'd9,         32'hF0F0_F0F0, 1'b0, 1'b0, 2};
        v[7]  = '{opm(OP_NAND), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0FF_F0FF, 1'b0, 1'b0, 2};
        v[8]  = '{opm(OP_XNOR), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F0F_0F0F, 1'b0, 1'b0, 2};
        v[9]  = '{opm(OP_SHL),  32'd1,         32'd33,        32'd2,         1'b0, 1'b0, 2};
        v[10] = '{opm(OP_SHRL), 32'h8000_0000, 32'd31,        32'd1,         1'b0, 1'b0, 2};
        v[11] = '{opm(OP_ROL),  32'h8000_0001, 32'd4,         32'h0000_0018, 1'b0, 1'b0, 2};
        v[12] = '{opm(OP_ROR),  32'd1,         32'd1,         32'h8000_0000, 1'b0, 1'b0, 2};
        v[13] = '{opm(OP_ROR),  32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0, 1'b0, 2};
        v[14] = '{opm(OP_SLT),  32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0, 1'b0, 2};
        v[15] = '{opm(OP_SLT),  32'd2,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 2};
        v[16] = '{opm(OP_BLT),  32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b1, 1'b0, 2};
        v[17] = '{opm(OP_BEQ),  32'd5,         32'd5,         32'd0,         1'b1, 1'b0, 2};
        v[18] = '{opm(OP_BEQ),  32'd5,         32'd6,         32'hFFFF_FFFF, 1'b0, 1'b0, 2};
        v[19] = '{opm(OP_BLT),  32'd1,         32'hFFFF_FFFE, 32'd3,         1'b0, 1'b0, 2};
        for (int i = 0; i < 20; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat);
            n_run++;
            if ({lat, result, zero, branch_taken, err} !==
                {v[i].lat, v[i].exp, (v[i].exp == '0), v[i].bt, v[i].er}) begin
                n_fail++;
                $display("FAIL vec%0d op=%h: got lat=%0d res=%h z=%b bt=%b err=%b expected lat=%0d res=%h bt=%b",
                         i, v[i].op, lat, result, zero, branch_taken, err, v[i].lat, v[i].exp, v[i].bt);
            end
        end
        // A non-branch op after a taken branch must clear branch_taken.
        run_op(opm(OP_BLT), 32'hFFFF_FFFE, 32'd1, lat);
        run_op(opm(OP_ADD), 32'd7, 32'd8, lat);
        n_run++;
        if ({result, branch_taken} !== {32'd15, 1'b0}) begin
            n_fail++;
            $display("FAIL bt_clear: got res=%h bt=%b expected f 0", result, branch_taken);
        end
    endtask

    task automatic test_divmod();
        vec_t v[5];
        int lat;
        v[0] = '{opm(OP_DIV), 32'd100,       32'd7, 32'd14,        1'b0, 1'b0, 34};
        v[1] = '{opm(OP_MOD), 32'd100,       32'd7, 32'd2,         1'b0, 1'b0, 34};
        v[2] = '{opm(OP_DIV), 32'd100,       32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 34};
        v[3] = '{opm(OP_MOD), 32'd100,       32'd0, 32'd100,       1'b0, 1'b1, 34};
        v[4] = '{opm(OP_DIV), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 34};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat);
            n_run++;
            if ({lat, result, err, branch_taken} !== {v[i].lat, v[i].exp, v[i].er, 1'b0}) begin
                n_fail++;
                $display("FAIL divmod%0d: got lat=%0d res=%h err=%b bt=%b expected lat=%0d res=%h err=%b",
                         i, lat, result, err, branch_taken, v[i].lat, v[i].exp, v[i].er);
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] ops[3];
        int lat;
        ops[0] = 17'h00003;
        ops[1] = 17'h00000;
        ops[2] = 17'h00018;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'd9, 32'd4, lat);
            n_run++;
            if ({lat, result, zero, err, branch_taken} !== {2, 32'd0, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL illegal op=%h: got lat=%0d res=%h z=%b err=%b expected lat=2 res=0 z=1 err=1",
                         ops[i], lat, result, zero, err);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  n_done = -1;
        int  extra  = 0;
        @(negedge clk);
        op_en = opm(OP_DIV); a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            if (n == 4) begin
                op_en = opm(OP_ADD); a = 32'd1; b = 32'd1; start = 1'b1;
            end
            if (n == 5) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                n_done = n;
                break;
            end
        end
        n_run++;
        if ({n_done, result} !== {34, 32'd14}) begin
            n_fail++;
            $display("FAIL b2b_busy_start: got lat=%0d res=%h expected 34 e", n_done, result);
        end
        // start held high during the done cycle must be ignored.
        op_en = opm(OP_ADD); a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (done || busy) extra++;
            @(posedge clk); #1;
        end
        n_run++;
        if ({extra, result} !== {0, 32'd14}) begin
            n_fail++;
            $display("FAIL b2b_done_cycle_start: got activity=%0d res=%h expected 0 e", extra, result);
        end
    endtask

    task automatic test_abort();
        int saw_done = 0;
        int lat;
        @(negedge clk);
        op_en = opm(ABORT_OP); a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (done) saw_done++;
            if (k == 3) begin
                op_en = opm(OP_ADD); a = 32'd8; b = 32'd8; start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_run++;
        if ({result, zero, branch_taken, busy, done, err} !== {32'd0, 5'b0}) begin
            n_fail++;
            $display("FAIL abort_outputs: got res=%h flags=%b expected 0 00000",
                     result, {zero, branch_taken, busy, done, err});
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        n_run++;
        if (saw_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", saw_done);
        end
        run_op(opm(OP_MUL), 32'd6, 32'd7, lat);
        n_run++;
        if ({lat, result} !== {MUL_LAT, 32'd42}) begin
            n_fail++;
            $display("FAIL abort_recover_mul: got lat=%0d res=%h expected %0d 2a", lat, result, MUL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_add_wrap();
        test_single_cycle();
        test_divmod();
        test_illegal();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
